// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI target (mode 0) block.
package spi_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  typedef logic [7:0] byte_t;

  localparam byte_t IDLE_BYTE_DEFAULT = 8'hFF;

endpackage

// File: rtl/spi_sync.sv
// Parameterised-depth single-bit synchroniser with a selectable reset value.
module spi_sync #(
  parameter int   DEPTH     = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] stages;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stages <= {DEPTH{RESET_VAL}};
    end else begin
      stages <= (stages << 1) | DEPTH'(d);
    end
  end

  assign q = stages[DEPTH-1];

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target: synchronised pins, byte shifter, one-entry tx holding register.
//   state    | meaning
//   ST_IDLE  | cs inactive, miso pad released, waiting for a cs falling edge
//   ST_SHIFT | cs active, shifting on sclk edges, bit counter tracks byte position
module spi_target
  import spi_pkg::*;
#(
  parameter int    SYNC_STAGES = 2,
  parameter byte_t IDLE_BYTE   = IDLE_BYTE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_cs,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_underrun
);

  localparam int FW = $clog2(SYNC_STAGES + 1);

  logic          cs_s, sclk_s, mosi_s;
  logic          cs_d, sclk_d;
  logic          cs_fall, cs_rise, sclk_rise, sclk_fall;
  logic [FW-1:0] flush_cnt;
  logic          cs_armed;
  state_t        state;
  logic [2:0]    bit_cnt;
  byte_t         rx_shift, tx_shift, hold_data, next_byte;
  logic          hold_full, miso_q, load_tx;

  spi_sync #(.DEPTH(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .d(spi_cs), .q(cs_s)
  );
  spi_sync #(.DEPTH(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(spi_sclk), .q(sclk_s)
  );
  spi_sync #(.DEPTH(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .d(spi_mosi), .q(mosi_s)
  );

  // A cs that is already low when reset releases must not look like a fresh select.
  assign cs_fall   = cs_armed & cs_d & ~cs_s;
  assign cs_rise   = ~cs_d & cs_s;
  assign sclk_rise = ~sclk_d & sclk_s;
  assign sclk_fall = sclk_d & ~sclk_s;

  assign next_byte = hold_full ? hold_data : IDLE_BYTE;
  assign load_tx   = ((state == ST_IDLE) && cs_fall) ||
                     ((state == ST_SHIFT) && !cs_rise && sclk_rise && (bit_cnt == 3'd7));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_d        <= 1'b1;
      sclk_d      <= 1'b0;
      flush_cnt   <= FW'(SYNC_STAGES);
      cs_armed    <= 1'b0;
      hold_data   <= '0;
      hold_full   <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      cs_d        <= cs_s;
      sclk_d      <= sclk_s;
      tx_underrun <= load_tx && !hold_full;
      if (flush_cnt != '0) begin
        flush_cnt <= flush_cnt - FW'(1);
      end else if (cs_s) begin
        cs_armed <= 1'b1;
      end
      if (load_tx && hold_full) begin
        hold_full <= 1'b0;
      end else if (tx_valid && !hold_full) begin
        hold_data <= tx_data;
        hold_full <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
      miso_q   <= 1'b1;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cs_fall) begin
            state    <= ST_SHIFT;
            bit_cnt  <= '0;
            miso_q   <= next_byte[7];
            tx_shift <= {next_byte[6:0], 1'b0};
          end
        end
        ST_SHIFT: begin
          if (cs_rise) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            rx_shift <= '0;
            tx_shift <= '0;
            miso_q   <= 1'b1;
          end else if (sclk_rise) begin
            rx_shift <= {rx_shift[6:0], mosi_s};
            bit_cnt  <= bit_cnt + 3'd1;
            // Next byte waits whole in tx_shift; its MSB goes out on the coming falling edge.
            if (bit_cnt == 3'd7) begin
              rx_data  <= {rx_shift[6:0], mosi_s};
              rx_valid <= 1'b1;
              tx_shift <= next_byte;
            end
          end else if (sclk_fall) begin
            miso_q   <= tx_shift[7];
            tx_shift <= {tx_shift[6:0], 1'b0};
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign tx_ready    = ~hold_full;
  assign spi_miso_oe = (state == ST_SHIFT);
  assign spi_miso    = (state == ST_SHIFT) ? miso_q : 1'b1;

endmodule

// File: tb/tb_spi_target.sv
// Self-checking bench for spi_target: directed scenarios plus random single-byte transfers.
module tb_spi_target;

  logic       clk, rst_n;
  logic       spi_cs, spi_sclk, spi_mosi, spi_miso, spi_miso_oe;
  logic [7:0] tx_data, rx_data;
  logic       tx_valid, tx_ready, rx_valid, tx_underrun;

  int tests = 0, fails = 0;
  int rxv_cnt = 0, ur_cnt = 0, rx_exp = 0, ur_exp = 0;
  logic [7:0] hold_q[$];

  spi_target #(.SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
    .clk(clk), .rst_n(rst_n), .spi_cs(spi_cs), .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) rxv_cnt++;
      if (tx_underrun) ur_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: each load takes the queued byte or falls back to the idle byte.
  task automatic model_load(output logic [7:0] b);
    if (hold_q.size() > 0) begin
      b = hold_q.pop_front();
    end else begin
      b = 8'hFF;
      ur_exp++;
    end
  endtask

  task automatic push_tx(input logic [7:0] b);
    int t = 0;
    while (!tx_ready && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    chk("tx_ready_wait", 32'(tx_ready), 1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    hold_q.push_back(b);
    chk("tx_ready_fall", 32'(tx_ready), 0);
  endtask

  task automatic cs_start();
    spi_cs = 1'b0;
    repeat (4) @(posedge clk); #1;
  endtask

  task automatic cs_end();
    repeat (4) @(posedge clk); #1;
    spi_cs = 1'b1;
    repeat (8) @(posedge clk); #1;
  endtask

  // Shifts nbits of mo (MSB first) at clk/8; a completed byte checks rx_valid timing and rx_data.
  task automatic spi_byte(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_mosi = mo[i];
      repeat (4) @(posedge clk); #1;
      mi[i] = spi_miso;
      spi_sclk = 1'b1;
      if (i == 0) begin
        repeat (2) @(posedge clk); #1;
        chk("rx_valid_early", 32'(rx_valid), 0);
        @(posedge clk); #1;
        chk("rx_valid_pulse", 32'(rx_valid), 1);
        chk("rx_data", 32'(rx_data), 32'(mo));
        @(posedge clk); #1;
        chk("rx_valid_width", 32'(rx_valid), 0);
      end else begin
        repeat (4) @(posedge clk); #1;
      end
      spi_sclk = 1'b0;
    end
  endtask

  task automatic xfer1(input logic [7:0] mo);
    logic [7:0] e, mi, dummy;
    model_load(e);
    cs_start();
    chk("start_underrun", ur_cnt, ur_exp);
    chk("oe_active", 32'(spi_miso_oe), 1);
    spi_byte(mo, 8, mi);
    rx_exp++;
    chk("miso_byte", 32'(mi), 32'(e));
    model_load(dummy);
    cs_end();
    chk("rx_count", rxv_cnt, rx_exp);
    chk("end_underrun", ur_cnt, ur_exp);
    chk("oe_idle", 32'(spi_miso_oe), 0);
    chk("miso_idle", 32'(spi_miso), 1);
  endtask

  initial begin
    logic [7:0] e0, e1, m0, m1, dummy, rb, rm;
    rst_n = 1'b0; spi_cs = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
    tx_valid = 1'b0; tx_data = 8'h00;
    repeat (3) @(posedge clk); #1;
    chk("rst_tx_ready", 32'(tx_ready), 1);
    chk("rst_rx_valid", 32'(rx_valid), 0);
    chk("rst_underrun", 32'(tx_underrun), 0);
    chk("rst_rx_data", 32'(rx_data), 0);
    chk("rst_miso", 32'(spi_miso), 1);
    chk("rst_oe", 32'(spi_miso_oe), 0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk); #1;

    // Queued A5 goes out while 3C comes in.
    push_tx(8'hA5);
    xfer1(8'h3C);
    chk("tx_ready_after_load", 32'(tx_ready), 1);

    // Nothing queued: idle byte.
    xfer1(8'h00);

    // Two-byte burst, second byte queued while the first shifts.
    push_tx(8'h11);
    repeat (10) @(posedge clk); #1;
    chk("tx_ready_hold", 32'(tx_ready), 0);
    model_load(e0);
    cs_start();
    chk("burst_start_underrun", ur_cnt, ur_exp);
    fork
      push_tx(8'h22);
      begin
        spi_byte(8'hC3, 8, m0);
        rx_exp++;
      end
    join
    chk("burst_miso0", 32'(m0), 32'(e0));
    model_load(e1);
    spi_byte(8'h5A, 8, m1);
    rx_exp++;
    chk("burst_miso1", 32'(m1), 32'(e1));
    model_load(dummy);
    cs_end();
    chk("burst_rx_count", rxv_cnt, rx_exp);
    chk("burst_underrun", ur_cnt, ur_exp);
    chk("burst_tx_ready", 32'(tx_ready), 1);

    // cs rises after 5 bits: partial byte dropped, counter restarts.
    model_load(e0);
    cs_start();
    spi_byte(8'hFF, 5, m0);
    chk("partial_miso", 32'(m0[7:3]), 32'(e0[7:3]));
    cs_end();
    chk("partial_no_rx", rxv_cnt, rx_exp);
    xfer1(8'h81);

    // Reset mid-transfer with cs held low; holding byte queued mid-transfer must be lost.
    model_load(e0);
    cs_start();
    push_tx(8'h77);
    spi_byte(8'h96, 3, m0);
    rst_n = 1'b0;
    #1;
    hold_q.delete();
    chk("mid_rst_oe", 32'(spi_miso_oe), 0);
    chk("mid_rst_miso", 32'(spi_miso), 1);
    chk("mid_rst_tx_ready", 32'(tx_ready), 1);
    chk("mid_rst_rx_data", 32'(rx_data), 0);
    chk("mid_rst_rx_valid", 32'(rx_valid), 0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk); #1;
    chk("post_rst_oe_cs_low", 32'(spi_miso_oe), 0);
    chk("post_rst_miso", 32'(spi_miso), 1);
    chk("post_rst_no_rx", rxv_cnt, rx_exp);
    spi_cs = 1'b1;
    repeat (8) @(posedge clk); #1;
    xfer1(8'h5A);

    // Random single-byte transfers, sometimes with a queued byte.
    for (int k = 0; k < 6; k++) begin
      rb = 8'($urandom_range(0, 255));
      rm = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) push_tx(rb);
      xfer1(rm);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
